// File: rtl/lcd_ctrl.sv
// HD44780-style LCD bus controller: turns single-cycle command strobes into
// setup / enable / hold / execution-wait bus cycles, runs the power-on init
// sequence after reset and buffers one pending command.
module lcd_ctrl #(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned EN_CYC        = 25,
    parameter int unsigned HOLD_CYC      = 4,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned EXEC_LONG_CYC = 82000,
    parameter int unsigned POR_CYC       = 2000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_vld,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    input  logic       i_lcd_on,
    input  logic       i_ovf_clr,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_overflow,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on
);

    localparam int unsigned MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int unsigned MAX_C   = (EXEC_LONG_CYC > POR_CYC) ? EXEC_LONG_CYC : POR_CYC;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Each timed state lasts N cycles: load N-1 on entry, leave when zero.
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(EXEC_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] LD_POR   = CNT_W'(POR_CYC - 1);

    typedef enum logic [2:0] {
        S_POR, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_IDLE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             act_rs, act_rs_n;
    logic [7:0]       act_data, act_data_n;
    logic             buf_vld, buf_vld_n;
    logic             buf_rs, buf_rs_n;
    logic [7:0]       buf_data, buf_data_n;
    logic [2:0]       init_idx, init_idx_n;
    logic             done, done_n;
    logic             ovf, ovf_n;
    logic             busy, busy_n;
    logic             en, en_n;
    logic             lcd_on;
    logic             drain;
    logic             ovf_set;
    logic             long_cmd;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    // Clear display / return home need the long execution wait.
    assign long_cmd = !act_rs && (act_data[7:2] == 6'd0) && (act_data != 8'd0);

    // Next-state, counter, command buffer and flag logic.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        act_rs_n   = act_rs;
        act_data_n = act_data;
        buf_vld_n  = buf_vld;
        buf_rs_n   = buf_rs;
        buf_data_n = buf_data;
        init_idx_n = init_idx;
        done_n     = done;
        drain      = 1'b0;
        ovf_set    = 1'b0;

        if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end

        case (state)
            S_POR: begin
                if (cnt == '0) begin
                    act_rs_n   = 1'b0;
                    act_data_n = init_byte(3'd0);
                    init_idx_n = 3'd1;
                    state_n    = S_SETUP;
                    cnt_n      = LD_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_n = S_EN_HI;
                    cnt_n   = LD_EN;
                end
            end
            S_EN_HI: begin
                if (cnt == '0) begin
                    state_n = S_HOLD;
                    cnt_n   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_n = S_WAIT;
                    cnt_n   = long_cmd ? LD_LONG : LD_EXEC;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    if (init_idx < 3'd4) begin
                        act_rs_n   = 1'b0;
                        act_data_n = init_byte(init_idx);
                        init_idx_n = init_idx + 3'd1;
                        state_n    = S_SETUP;
                        cnt_n      = LD_SETUP;
                    end else begin
                        done_n = 1'b1;
                        if (buf_vld) begin
                            drain      = 1'b1;
                            act_rs_n   = buf_rs;
                            act_data_n = buf_data;
                            state_n    = S_SETUP;
                            cnt_n      = LD_SETUP;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                end
            end
            S_IDLE: begin
                // A command buffered on the WAIT->IDLE edge is started from here.
                if (buf_vld) begin
                    drain      = 1'b1;
                    act_rs_n   = buf_rs;
                    act_data_n = buf_data;
                    state_n    = S_SETUP;
                    cnt_n      = LD_SETUP;
                end
            end
            default: begin
                state_n = S_POR;
                cnt_n   = LD_POR;
            end
        endcase

        if (drain) begin
            buf_vld_n = 1'b0;
        end

        // Draining frees the buffer before the new strobe is considered.
        if (i_cmd_vld) begin
            if (state == S_IDLE && !buf_vld) begin
                act_rs_n   = i_cmd_rs;
                act_data_n = i_cmd_data;
                state_n    = S_SETUP;
                cnt_n      = LD_SETUP;
            end else if (!buf_vld || drain) begin
                buf_vld_n  = 1'b1;
                buf_rs_n   = i_cmd_rs;
                buf_data_n = i_cmd_data;
            end else begin
                ovf_set = 1'b1;
            end
        end

        ovf_n  = ovf_set ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf);
        busy_n = (state_n != S_IDLE) || buf_vld_n;
        en_n   = (state_n == S_EN_HI);
    end

    // State and registered outputs; reset forces EN low at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_POR;
            cnt      <= LD_POR;
            act_rs   <= 1'b0;
            act_data <= '0;
            buf_vld  <= 1'b0;
            buf_rs   <= 1'b0;
            buf_data <= '0;
            init_idx <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            en       <= 1'b0;
            lcd_on   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            act_rs   <= act_rs_n;
            act_data <= act_data_n;
            buf_vld  <= buf_vld_n;
            buf_rs   <= buf_rs_n;
            buf_data <= buf_data_n;
            init_idx <= init_idx_n;
            done     <= done_n;
            ovf      <= ovf_n;
            busy     <= busy_n;
            en       <= en_n;
            lcd_on   <= i_lcd_on;
        end
    end

    assign o_busy      = busy;
    assign o_init_done = done;
    assign o_overflow  = ovf;
    assign o_lcd_data  = act_data;
    assign o_lcd_rs    = act_rs;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en;
    assign o_lcd_on    = lcd_on;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed scenarios plus randomized
// commands, checked against a transaction-level timing model of the bus.
module tb_lcd_ctrl;

    localparam int SU  = 2;
    localparam int EN  = 3;
    localparam int HO  = 2;
    localparam int EX  = 5;
    localparam int EXL = 10;
    localparam int POR = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_cmd_vld = 1'b0;
    logic       i_cmd_rs = 1'b0;
    logic [7:0] i_cmd_data = 8'h00;
    logic       i_lcd_on = 1'b1;
    logic       i_ovf_clr = 1'b0;
    logic       o_busy, o_init_done, o_overflow, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
    logic [7:0] o_lcd_data;

    lcd_ctrl #(
        .SETUP_CYC(SU), .EN_CYC(EN), .HOLD_CYC(HO),
        .EXEC_CYC(EX), .EXEC_LONG_CYC(EXL), .POR_CYC(POR)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd_vld(i_cmd_vld), .i_cmd_rs(i_cmd_rs),
        .i_cmd_data(i_cmd_data), .i_lcd_on(i_lcd_on), .i_ovf_clr(i_ovf_clr),
        .o_busy(o_busy), .o_init_done(o_init_done), .o_overflow(o_overflow),
        .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int stable_err = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         start;
        int         len;
    } pulse_t;

    pulse_t act_q[$];
    pulse_t exp_q[$];

    // Cycle counter: value N during the cycle after the N-th rising edge.
    always @(posedge i_clk) cyc <= cyc + 1;

    logic   prev_en = 1'b0;
    pulse_t cur;
    int     hold_left = 0;

    // Bus monitor: records every EN pulse and checks bus stability under EN and hold.
    always @(negedge i_clk) begin
        if (!mon_en) begin
            prev_en   = 1'b0;
            hold_left = 0;
        end else begin
            if (o_lcd_en && !prev_en) begin
                cur.rs    = o_lcd_rs;
                cur.data  = o_lcd_data;
                cur.start = cyc;
                cur.len   = 0;
            end
            if (o_lcd_en) begin
                cur.len++;
                if (o_lcd_rs !== cur.rs || o_lcd_data !== cur.data) stable_err++;
            end else if (prev_en) begin
                act_q.push_back(cur);
                hold_left = HO;
            end
            if (!o_lcd_en && hold_left > 0) begin
                if (o_lcd_rs !== cur.rs || o_lcd_data !== cur.data) stable_err++;
                hold_left--;
            end
            prev_en = o_lcd_en;
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int outs();
        return int'({o_busy, o_init_done, o_overflow, o_lcd_data,
                     o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on});
    endfunction

    // Clear/home instructions (RS=0, byte 1..3) take the long execution time.
    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && int'(d) >= 1 && int'(d) <= 3) ? EXL : EX;
    endfunction

    // Expect one transfer whose setup begins at cycle `setup`; returns the
    // first cycle after its execution wait.
    task automatic add_exp(input logic rs, input logic [7:0] d, input int setup, output int nxt);
        pulse_t p;
        p.rs    = rs;
        p.data  = d;
        p.start = setup + SU;
        p.len   = EN;
        exp_q.push_back(p);
        nxt = setup + SU + EN + HO + wait_of(rs, d);
    endtask

    task automatic compare_pulses(input string tag);
        pulse_t a, e;
        chk({tag, "_pulse_count"}, act_q.size(), exp_q.size());
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_rs_data"}, int'({a.rs, a.data}), int'({e.rs, e.data}));
            chk({tag, "_en_start"}, a.start, e.start);
            chk({tag, "_en_len"}, a.len, e.len);
        end
        act_q.delete();
        exp_q.delete();
        chk({tag, "_bus_stable_errs"}, stable_err, 0);
        stable_err = 0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge i_clk);
    endtask

    task automatic cmd(input logic rs, input logic [7:0] d);
        i_cmd_vld  = 1'b1;
        i_cmd_rs   = rs;
        i_cmd_data = d;
        @(negedge i_clk);
        i_cmd_vld  = 1'b0;
    endtask

    logic [7:0] init_rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    logic       tab_rs   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] tab_d    [5] = '{8'h02, 8'h04, 8'h01, 8'h00, 8'h03};

    initial begin
        int r, c, s, f1, f2, f3;
        logic       rs1, rs2;
        logic [7:0] d1, d2;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("reset_outputs", outs(), 0);

        // Power-on init sequence
        i_rst  = 1'b0;
        r      = cyc;
        mon_en = 1'b1;
        s = r + POR;
        for (int i = 0; i < 4; i++) add_exp(1'b0, init_rom[i], s, s);
        wait_to(r + 1);
        chk("lcd_on_after_reset", int'(o_lcd_on), 1);
        wait_to(r + 30);
        chk("busy_during_init", int'(o_busy), 1);
        wait_to(r + 60);
        chk("busy_done_before", int'({o_busy, o_init_done}), 2);
        wait_to(r + 61);
        chk("busy_done_at_61", int'({o_busy, o_init_done}), 1);
        compare_pulses("init");

        // o_lcd_on one-cycle latency
        i_lcd_on = 1'b0;
        chk("lcd_on_same_cycle", int'(o_lcd_on), 1);
        @(negedge i_clk);
        chk("lcd_on_next_cycle", int'(o_lcd_on), 0);
        i_lcd_on = 1'b1;
        @(negedge i_clk);

        // Single data write
        c = cyc;
        cmd(1'b1, 8'h41);
        chk("single_bus_next_cycle", int'({o_lcd_rs, o_lcd_data, o_lcd_en}), int'({1'b1, 8'h41, 1'b0}));
        add_exp(1'b1, 8'h41, c + 1, f1);
        wait_to(f1 - 1);
        chk("single_busy_before_end", int'(o_busy), 1);
        wait_to(f1);
        chk("single_busy_low", int'(o_busy), 0);
        compare_pulses("single");

        // Three back-to-back strobes; clear on the dropping cycle loses to set
        c = cyc;
        cmd(1'b1, 8'h41);
        cmd(1'b1, 8'h42);
        i_ovf_clr = 1'b1;
        cmd(1'b1, 8'h43);
        i_ovf_clr = 1'b0;
        chk("burst_overflow_set", int'(o_overflow), 1);
        add_exp(1'b1, 8'h41, c + 1, f1);
        add_exp(1'b1, 8'h42, f1, f2);
        wait_to(f2);
        chk("burst_busy_ovf_end", int'({o_busy, o_overflow}), 1);
        i_ovf_clr = 1'b1;
        @(negedge i_clk);
        i_ovf_clr = 1'b0;
        chk("overflow_cleared", int'(o_overflow), 0);
        compare_pulses("burst");

        // New strobe on the exact cycle the buffer drains
        c = cyc;
        cmd(1'b1, 8'h41);
        cmd(1'b1, 8'h42);
        add_exp(1'b1, 8'h41, c + 1, f1);
        wait_to(f1 - 1);
        cmd(1'b1, 8'h44);
        add_exp(1'b1, 8'h42, f1, f2);
        add_exp(1'b1, 8'h44, f2, f3);
        chk("drain_overflow_clear", int'(o_overflow), 0);
        wait_to(f3 - 1);
        chk("drain_busy_before_end", int'(o_busy), 1);
        wait_to(f3);
        chk("drain_busy_ovf_end", int'({o_busy, o_overflow}), 0);
        compare_pulses("drain");

        // Execution-wait selection
        for (int i = 0; i < 5; i++) begin
            c = cyc;
            cmd(tab_rs[i], tab_d[i]);
            add_exp(tab_rs[i], tab_d[i], c + 1, f1);
            wait_to(f1 - 1);
            chk($sformatf("wait_busy_hi_%0d", i), int'(o_busy), 1);
            wait_to(f1);
            chk($sformatf("wait_busy_lo_%0d", i), int'(o_busy), 0);
            compare_pulses($sformatf("wait_%0d", i));
        end

        // Randomized single commands and buffered pairs
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            rs1 = 1'($urandom_range(0, 1));
            rs2 = 1'($urandom_range(0, 1));
            d1  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            d2  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            c = cyc;
            cmd(rs1, d1);
            add_exp(rs1, d1, c + 1, f1);
            if ($urandom_range(0, 1) == 1) begin
                cmd(rs2, d2);
                add_exp(rs2, d2, f1, f1);
            end
            wait_to(f1 - 1);
            chk($sformatf("rand_busy_hi_%0d", i), int'(o_busy), 1);
            wait_to(f1);
            chk($sformatf("rand_busy_lo_ovf_%0d", i), int'({o_busy, o_overflow}), 0);
            compare_pulses($sformatf("rand_%0d", i));
        end

        // Asynchronous reset while EN is high, then init replay with a command queued in POR
        c = cyc;
        cmd(1'b1, 8'h5A);
        wait_to(c + 4);
        chk("midxfer_en_high", int'(o_lcd_en), 1);
        mon_en = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        chk("midxfer_reset_outputs", outs(), 0);
        act_q.delete();
        exp_q.delete();
        stable_err = 0;
        repeat (2) @(negedge i_clk);
        i_rst  = 1'b0;
        r      = cyc;
        mon_en = 1'b1;
        s = r + POR;
        for (int i = 0; i < 4; i++) add_exp(1'b0, init_rom[i], s, s);
        add_exp(1'b1, 8'h55, s, f1);
        wait_to(r + 3);
        cmd(1'b1, 8'h55);
        wait_to(r + 30);
        chk("replay_busy_init", int'(o_busy), 1);
        wait_to(r + 60);
        chk("replay_done_before", int'(o_init_done), 0);
        wait_to(r + 61);
        chk("replay_busy_done_61", int'({o_busy, o_init_done}), 3);
        wait_to(f1 - 1);
        chk("replay_busy_before_end", int'(o_busy), 1);
        wait_to(f1);
        chk("replay_busy_low", int'({o_busy, o_overflow}), 0);
        compare_pulses("replay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
